// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SRL  = 4'd3,
    OP_OR   = 4'd4,
    OP_AND  = 4'd5,
    OP_XOR  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_MUL  = 4'd9,
    OP_DIVU = 4'd10,
    OP_REMU = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_e;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Bit-serial datapath: shift-add multiply (low half) and restoring unsigned divide.
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res
);

  logic [SHW:0]     r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_md;
  logic             r_mul;
  logic             r_remsel;

  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_acc_n;
  logic [WIDTH-1:0] w_rem_n;
  logic [WIDTH-1:0] w_md_n;

  // MUL: r_acc = multiplier, r_md = shifted multiplicand, r_rem = partial product.
  // DIV: r_acc = dividend shifting into quotient, r_md = divisor, r_rem = remainder.
  always_comb begin
    w_trial = {r_rem, r_acc[WIDTH-1]};
    w_diff  = w_trial - {1'b0, r_md};
    if (r_mul) begin
      w_rem_n = r_acc[0] ? (r_rem + r_md) : r_rem;
      w_md_n  = r_md << 1;
      w_acc_n = r_acc >> 1;
    end else begin
      w_rem_n = w_diff[WIDTH] ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_md_n  = r_md;
      w_acc_n = {r_acc[WIDTH-2:0], ~w_diff[WIDTH]};
    end
  end

  // Result reflects the step being taken this cycle so the final value is ready with o_done.
  assign o_res  = (r_mul || r_remsel) ? w_rem_n : w_acc_n;
  assign o_done = (r_cnt == (SHW+1)'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_md     <= '0;
      r_mul    <= 1'b0;
      r_remsel <= 1'b0;
    end else if (i_start) begin
      r_cnt    <= (SHW+1)'(WIDTH);
      r_mul    <= (i_op == OP_MUL);
      r_remsel <= (i_op == OP_REMU);
      r_acc    <= (i_op == OP_MUL) ? i_b : i_a;
      r_md     <= (i_op == OP_MUL) ? i_a : i_b;
      r_rem    <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - (SHW+1)'(1);
      r_acc <= w_acc_n;
      r_rem <= w_rem_n;
      r_md  <= w_md_n;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: IDLE/CALC/FIN control, single-cycle ops, iterative MUL/DIVU/REMU.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       OP,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] ALUOut,
  output logic             ZERODETECT,
  output logic             ILLEGAL
);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic             r_multi;

  logic             w_accept;
  logic             w_md_start;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_res;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_res;
  logic             w_ill;
  logic [WIDTH-1:0] w_out;
  logic             w_out_ill;

  assign w_accept   = (r_state == S_IDLE) && START;
  // Divide by zero bypasses the iterative path and resolves in a single CALC cycle.
  assign w_md_start = w_accept && is_iter_op(OP) && ((OP == OP_MUL) || (B != '0));

  seq_alu_muldiv #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_muldiv (
    .i_clk  (CLK),
    .i_rst_n(RST_N),
    .i_start(w_md_start),
    .i_op   (OP),
    .i_a    (A),
    .i_b    (B),
    .o_done (w_md_done),
    .o_res  (w_md_res)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (START) w_next = S_CALC;
      S_CALC:  if (!r_multi || w_md_done) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY = (r_state != S_IDLE);
    DONE = (r_state == S_FIN);
  end

  assign w_sh = r_b[SHW-1:0];

  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    case (r_op)
      OP_ADD:  w_res = r_a + r_b;
      OP_SUB:  w_res = r_a - r_b;
      OP_SLL:  w_res = r_a << w_sh;
      OP_SRL:  w_res = r_a >> w_sh;
      OP_OR:   w_res = r_a | r_b;
      OP_AND:  w_res = r_a & r_b;
      OP_XOR:  w_res = r_a ^ r_b;
      OP_SRA:  w_res = $signed(r_a) >>> w_sh;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      OP_DIVU: w_res = '1;
      OP_REMU: w_res = r_a;
      OP_MUL:  w_res = '0;
      default: w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_out     = r_multi ? w_md_res : w_res;
    w_out_ill = r_multi ? 1'b0 : w_ill;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_multi    <= 1'b0;
      ALUOut     <= '0;
      ZERODETECT <= 1'b1;
      ILLEGAL    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= A;
        r_b     <= B;
        r_op    <= OP;
        r_multi <= w_md_start;
      end
      if ((r_state == S_CALC) && (w_next == S_FIN)) begin
        ALUOut     <= w_out;
        ZERODETECT <= (w_out == '0);
        ILLEGAL    <= w_out_ill;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu with a queue-based scoreboard checked on each DONE.
module tb_seq_alu;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  OP;
  logic        BUSY;
  logic        DONE;
  logic [15:0] ALUOut;
  logic        ZERODETECT;
  logic        ILLEGAL;

  seq_alu #(.WIDTH(16)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ALUOut    (ALUOut),
    .ZERODETECT(ZERODETECT),
    .ILLEGAL   (ILLEGAL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] res;
    logic        zero;
    logic        ill;
    int          cyc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ill;
    int          lat;
    bit          hold;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   busy_run = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per DONE pulse.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST_N) busy_run = 0;
    else begin
      if (BUSY) busy_run++;
      if (DONE) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got DONE=1 expected no DONE (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("aluout", ALUOut, e.res);
          chk("zerodetect", ZERODETECT, e.zero);
          chk("illegal", ILLEGAL, e.ill);
          chk("done_cycle", cyc, e.cyc);
          chk("busy_cycles", busy_run, e.lat);
        end
        busy_run = 0;
      end
    end
  end

  task automatic issue(input vec_t v);
    exp_t e;
    int   t;
    START = 1'b1; OP = v.op; A = v.a; B = v.b;
    e.res = v.res; e.zero = (v.res == 16'h0); e.ill = v.ill;
    e.cyc = cyc + v.lat; e.lat = v.lat;
    sb.push_back(e);
    t = 0;
    do begin
      @(negedge CLK);
      if (v.hold) begin
        START = 1'b1; OP = 4'(t); A = 16'hDEAD ^ 16'(t); B = 16'h0000;
      end else START = 1'b0;
      t++;
    end while (!DONE && t < 100);
    if (!DONE) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no DONE expected DONE within %0d cycles", t);
    end
    START = 1'b0;
    @(negedge CLK);
  endtask

  task automatic addv(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] res, input logic ill, input int lat, input bit hold);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.ill = ill; v.lat = lat; v.hold = hold;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int s;
    RST_N = 1'b0; START = 1'b0; A = '0; B = '0; OP = '0;
    addv(4'd0,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 2,  1'b0);
    addv(4'd1,  16'h0005, 16'h0007, 16'hFFFE, 1'b0, 2,  1'b0);
    addv(4'd2,  16'h0001, 16'h0014, 16'h0010, 1'b0, 2,  1'b1);
    addv(4'd3,  16'h8000, 16'h0003, 16'h1000, 1'b0, 2,  1'b0);
    addv(4'd4,  16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0, 2,  1'b0);
    addv(4'd5,  16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 2,  1'b0);
    addv(4'd6,  16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 2,  1'b0);
    addv(4'd7,  16'h8000, 16'h0013, 16'hF000, 1'b0, 2,  1'b0);
    addv(4'd8,  16'hFFFF, 16'h0001, 16'h0001, 1'b0, 2,  1'b0);
    addv(4'd8,  16'h0001, 16'hFFFF, 16'h0000, 1'b0, 2,  1'b0);
    addv(4'd9,  16'h0123, 16'h0010, 16'h1230, 1'b0, 17, 1'b1);
    addv(4'd9,  16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 17, 1'b0);
    addv(4'd10, 16'd100,  16'd7,    16'd14,   1'b0, 17, 1'b0);
    addv(4'd11, 16'd100,  16'd7,    16'd2,    1'b0, 17, 1'b1);
    addv(4'd10, 16'hFFFF, 16'h0010, 16'h0FFF, 1'b0, 17, 1'b0);
    addv(4'd11, 16'hFFFF, 16'h0010, 16'h000F, 1'b0, 17, 1'b0);
    addv(4'd10, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 2,  1'b0);
    addv(4'd11, 16'h1234, 16'h0000, 16'h1234, 1'b0, 2,  1'b0);
    addv(4'd13, 16'h1234, 16'h5678, 16'h0000, 1'b1, 2,  1'b0);
    addv(4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 2,  1'b0);

    // Reset state, with START held to confirm it has no effect under reset.
    repeat (3) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_aluout", ALUOut, 16'h0000);
    chk("rst_zero", ZERODETECT, 1'b1);
    chk("rst_illegal", ILLEGAL, 1'b0);
    START = 1'b0;
    RST_N = 1'b1;
    @(negedge CLK);

    foreach (vecs[i]) issue(vecs[i]);

    // Abort a MUL by reset: stray START at +5, reset at +8.
    START = 1'b1; OP = 4'd9; A = 16'h0003; B = 16'h0005;
    s = cyc + 1;
    @(negedge CLK);
    START = 1'b0;
    while (cyc < s + 4) @(negedge CLK);
    START = 1'b1; OP = 4'd0;
    @(negedge CLK);
    START = 1'b0;
    while (cyc < s + 7) @(negedge CLK);
    chk("abort_busy_before", BUSY, 1'b1);
    RST_N = 1'b0;
    #1;
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_done", DONE, 1'b0);
    chk("abort_aluout", ALUOut, 16'h0000);
    chk("abort_zero", ZERODETECT, 1'b1);
    chk("abort_illegal", ILLEGAL, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (25) @(negedge CLK);
    chk("abort_idle", BUSY, 1'b0);

    issue(vecs[0]);
    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
